// File: rtl/pipe_add_sub.sv
// Segment-pipelined W-bit adder/subtractor: one SEG-bit slice per stage, with the
// carry registered between stages, so one result leaves per cycle after W/SEG cycles.
module pipe_add_sub #(
  parameter int W   = 32,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int S = W / SEG;

  if (SEG < 1 || (W % SEG) != 0 || S < 1 || S > 16) begin : g_cfg_check
    $error("pipe_add_sub: W must be a multiple of SEG with 1 <= W/SEG <= 16");
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage k holds the operand slices not yet added (slice k at the bottom) and
  // the result slices already produced by stages 0..k-1.
  for (genvar k = 0; k < S; k++) begin : stg
    logic                   v_r;
    logic                   c_r;
    logic [W-SEG*k-1:0]     a_r;
    logic [W-SEG*k-1:0]     bx_r;
    logic [SEG:0]           add;
    logic [SEG*(k+1)-1:0]   sum_o;

    assign add = {1'b0, a_r[SEG-1:0]} + {1'b0, bx_r[SEG-1:0]} + {{SEG{1'b0}}, c_r};

    if (k == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_r  <= 1'b0;
          c_r  <= 1'b0;
          a_r  <= '0;
          bx_r <= '0;
        end else if (en) begin
          v_r  <= in_valid;
          c_r  <= sub ? ~cin : cin;
          a_r  <= a;
          bx_r <= sub ? ~b : b;
        end
      end
      assign sum_o = add[SEG-1:0];
    end else begin : g_body
      logic [SEG*k-1:0] sum_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_r   <= 1'b0;
          c_r   <= 1'b0;
          a_r   <= '0;
          bx_r  <= '0;
          sum_r <= '0;
        end else if (en) begin
          v_r   <= stg[k-1].v_r;
          c_r   <= stg[k-1].add[SEG];
          a_r   <= stg[k-1].a_r[W-SEG*(k-1)-1:SEG];
          bx_r  <= stg[k-1].bx_r[W-SEG*(k-1)-1:SEG];
          sum_r <= stg[k-1].sum_o;
        end
      end
      assign sum_o = {add[SEG-1:0], sum_r};
    end
  end

  // Last stage still holds the top operand slice, so its MSBs are the sign bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= stg[S-1].v_r;
      s         <= stg[S-1].sum_o;
      cout      <= stg[S-1].add[SEG];
      ovf       <= (stg[S-1].a_r[SEG-1] == stg[S-1].bx_r[SEG-1]) &&
                   (stg[S-1].sum_o[W-1] != stg[S-1].a_r[SEG-1]);
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: a 4-stage 32/8 instance and a
// single-stage 16/16 instance, each with a whole-word arithmetic scoreboard.
module tb_pipe_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv0, ir0, cin0, sub0, ov0, or0, co0, of0;
  logic [31:0] a0, b0, s0;
  logic        iv1, ir1, cin1, sub1, ov1, or1, co1, of1;
  logic [15:0] a1, b1, s1;

  int vecs = 0;
  int errs = 0;

  pipe_add_sub #(.W(32), .SEG(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .s(s0),
    .cout(co0), .ovf(of0));

  pipe_add_sub #(.W(16), .SEG(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .s(s1),
    .cout(co1), .ovf(of1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    vecs++;
    errs++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference: whole-word arithmetic, result packed as {ovf, cout, s}.
  function automatic logic [33:0] model0(input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input logic sb);
    logic [31:0] bx;
    logic [32:0] t;
    bx = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bx} + {32'd0, (sb ? !c : c)};
    return {(a[31] == bx[31]) && (t[31] != a[31]), t[32], t[31:0]};
  endfunction

  function automatic logic [17:0] model1(input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input logic sb);
    logic [15:0] bx;
    logic [16:0] t;
    bx = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bx} + {16'd0, (sb ? !c : c)};
    return {(a[15] == bx[15]) && (t[15] != a[15]), t[16], t[15:0]};
  endfunction

  // Scoreboards: handshakes are observed at the falling edge, while everything is stable.
  logic [33:0] q0[$];
  logic [33:0] e0;
  logic [34:0] snap0;
  logic        stall0 = 1'b0;
  int          nout0 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      stall0 = 1'b0;
    end else begin
      if (stall0) check("dut0_hold", {ov0, of0, co0, s0}, snap0);
      if (ov0 && !or0) check("dut0_stall_in_ready", ir0, 1'b0);
      if (ov0 && or0) begin
        if (q0.size() == 0) fail("dut0_spurious", $sformatf("unexpected result s=%h", s0));
        else begin
          e0 = q0.pop_front();
          check("dut0_result", {of0, co0, s0}, e0);
          nout0++;
        end
      end
      if (iv0 && ir0) q0.push_back(model0(a0, b0, cin0, sub0));
      stall0 = ov0 && !or0;
      snap0  = {ov0, of0, co0, s0};
    end
  end

  logic [17:0] q1[$];
  logic [17:0] e1;
  logic [18:0] snap1;
  logic        stall1 = 1'b0;
  int          acc1 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      stall1 = 1'b0;
    end else begin
      if (stall1) check("dut1_hold", {ov1, of1, co1, s1}, snap1);
      if (ov1 && !or1) check("dut1_stall_in_ready", ir1, 1'b0);
      if (ov1 && or1) begin
        if (q1.size() == 0) fail("dut1_spurious", $sformatf("unexpected result s=%h", s1));
        else begin
          e1 = q1.pop_front();
          check("dut1_result", {of1, co1, s1}, e1);
        end
      end
      if (iv1 && ir1) begin
        q1.push_back(model1(a1, b1, cin1, sub1));
        acc1++;
      end
      stall1 = ov1 && !or1;
      snap1  = {ov1, of1, co1, s1};
    end
  end

  // Called just after a rising edge; returns just after the accepting edge with iv0 low.
  task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sb);
    bit acc;
    acc = 1'b0;
    iv0 = 1'b1; a0 = a; b0 = b; cin0 = c; sub0 = sb;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir0) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!acc) fail("dut0_accept_timeout", "in_ready never rose");
    @(posedge clk); #1;
    iv0 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb);
    bit acc;
    acc = 1'b0;
    iv1 = 1'b1; a1 = a; b1 = b; cin1 = c; sub1 = sb;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir1) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!acc) fail("dut1_accept_timeout", "in_ready never rose");
    @(posedge clk); #1;
    iv1 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl[6];

  // Sends one directed beat to dut0 with out_ready high, measures latency, checks result.
  task automatic directed0(input vec_t v, input string tag);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    send0(v.a, v.b, v.cin, v.sub);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ov0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail({tag, "_timeout"}, "out_valid never rose");
    else begin
      check({tag, "_latency"}, lat, 4);
      check({tag, "_s"}, s0, v.s);
      check({tag, "_cout"}, co0, v.cout);
      check({tag, "_ovf"}, of0, v.ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int ghosts;
    int lat;
    int base;
    bit got;
    logic [17:0] ex1;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[4] = '{32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
    tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};

    rst_n = 1'b0;
    iv0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; or0 = 1'b1;
    iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; or1 = 1'b1;
    #1;
    check("rst_out_valid", ov0, 1'b0);
    check("rst_s", s0, 32'd0);
    check("rst_cout", co0, 1'b0);
    check("rst_ovf", of0, 1'b0);
    check("rst_dut1_out_valid", ov1, 1'b0);
    #20;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", ir0, 1'b1);

    foreach (tbl[i]) directed0(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: 8 back-to-back beats, 3-cycle stall mid-stream.
    base = nout0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send0($urandom, $urandom, 1'($urandom_range(0, 1)), 1'(i % 2));
      end
      begin
        repeat (5) @(posedge clk);
        #1 or0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 or0 = 1'b1;
      end
    join
    for (int i = 0; i < 30 && q0.size() != 0; i++) @(posedge clk);
    #1;
    check("bp_drained", q0.size(), 0);
    check("bp_result_count", nout0 - base, 8);

    // Random traffic on dut0 with random out_ready.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      iv0 = 1'($urandom_range(0, 3) != 0);
      a0 = $urandom; b0 = $urandom;
      cin0 = 1'($urandom_range(0, 1)); sub0 = 1'($urandom_range(0, 1));
      or0 = 1'($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    iv0 = 1'b0; or0 = 1'b1;
    for (int i = 0; i < 30 && q0.size() != 0; i++) @(posedge clk);
    #1;
    check("rand0_drained", q0.size(), 0);

    // Reset mid-stream: first beat stalls at the output, three more in flight.
    or0 = 1'b0;
    for (int i = 0; i < 4; i++) send0($urandom, $urandom, 1'b0, 1'(i % 2));
    @(posedge clk); #2;
    check("pre_reset_out_valid", ov0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_out_valid_drop", ov0, 1'b0);
    check("reset_s_clear", s0, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    or0 = 1'b1;
    ghosts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov0) ghosts++;
    end
    check("reset_no_ghosts", ghosts, 0);
    @(posedge clk); #1;
    directed0(tbl[3], "post_reset");

    // Single-stage instance: latency 1, then 1000 random beats.
    send1(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    ex1 = {1'b1, 1'b0, 16'h8000};
    lat = 0;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ov1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail("dut1_latency_timeout", "out_valid never rose");
    else begin
      check("dut1_latency", lat, 1);
      check("dut1_directed", {of1, co1, s1}, ex1);
    end
    @(posedge clk); #1;

    acc1 = 0;
    for (int i = 0; i < 6000 && acc1 < 1000; i++) begin
      @(posedge clk); #1;
      iv1 = 1'($urandom_range(0, 3) != 0);
      a1 = 16'($urandom); b1 = 16'($urandom);
      cin1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
      or1 = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    iv1 = 1'b0; or1 = 1'b1;
    if (acc1 < 1000) fail("dut1_rand_timeout", $sformatf("only %0d beats accepted", acc1));
    for (int i = 0; i < 20 && q1.size() != 0; i++) @(posedge clk);
    #1;
    check("rand1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
